bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define BIN_TO_BCD_SEQ_SIGNED_EN to treat bin as two's complement and report its sign.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,  // 4..32
  parameter int DIGITS = 4    // 1..10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  sign
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [BIN_W-1:0] shreg;
  logic [BIN_W-1:0] mag;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_nxt;
  logic             carry_out;
  logic [CNT_W-1:0] cnt;
  logic             ovf_work;
  logic             accept;
  logic             last_step;

  // A request landing mid-conversion is dropped, not queued.
  assign accept    = start && (state != SHIFT);
  assign last_step = (state == SHIFT) && (cnt == LAST_STEP);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    {carry_out, acc_nxt} = {acc_adj, shreg[BIN_W-1]};
  end

`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
  logic sign_work;

  // Negating the most negative value wraps to 2^(BIN_W-1), which is the
  // correct magnitude when read as unsigned.
  assign mag = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_work <= 1'b0;
      sign      <= 1'b0;
    end else begin
      if (accept)    sign_work <= bin[BIN_W-1];
      if (last_step) sign      <= sign_work;
    end
  end
`else
  assign mag  = bin;
  assign sign = 1'b0;
`endif

  // Result registers update only on the final step, so they hold steady
  // for the whole of the next conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      shreg    <= mag;
      acc      <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
    end else if (state == SHIFT) begin
      shreg    <= shreg << 1;
      acc      <= acc_nxt;
      cnt      <= cnt + 1'b1;
      ovf_work <= ovf_work | carry_out;
      if (last_step) begin
        bcd      <= acc_nxt;
        overflow <= ovf_work | carry_out;
      end
    end
  end

endmodule
